// File: rtl/mips_pkg.sv
// Shared types and constants for the pipelined multiplier.
package mips_pkg;

    localparam int MULT_STAGES = 5;
    localparam int MULT_BYTE_W = 8;
    localparam int MULT_DATA_W = 32;
    localparam int MULT_ADDR_W = 5;
    localparam int MULT_ACC_W  = 64;

    typedef struct packed {
        logic                   valid;
        logic [MULT_ADDR_W-1:0] dest;
        logic [MULT_DATA_W-1:0] a;
        logic [MULT_DATA_W-1:0] b;
        logic [MULT_ACC_W-1:0]  acc;
        logic                   sign;
    } t_mult_stage;

    // Magnitude of a two's-complement word; -2^31 maps to 0x8000_0000 unsigned.
    function automatic logic [MULT_DATA_W-1:0] mag32(input logic [MULT_DATA_W-1:0] v);
        return v[MULT_DATA_W-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mips_mult_byte_step.sv
// One shift-add step: acc_out = acc_in + (a * byte_in) << (8 * shift_idx).
module mips_mult_byte_step
    import mips_pkg::*;
(
    input  logic [MULT_ACC_W-1:0]  acc_in,
    input  logic [MULT_DATA_W-1:0] a,
    input  logic [MULT_BYTE_W-1:0] byte_in,
    input  logic [1:0]             shift_idx,
    output logic [MULT_ACC_W-1:0]  acc_out
);

    logic [39:0]           pp;
    logic [MULT_ACC_W-1:0] pp_ext;

    always_comb begin
        pp      = {8'd0, a} * {32'd0, byte_in};
        pp_ext  = {24'd0, pp} << {shift_idx, 3'b000};
        acc_out = acc_in + pp_ext;
    end

endmodule

// File: rtl/mips_mult_pipe.sv
// Five-stage (P0..P3, W) shift-add 32x32 multiplier driving the register-file write port.
// Optional signed multiply is built in when MULT_SIGNED_EN is defined.
`ifndef MIPS_DFF_AR
`define MIPS_DFF_AR(clk_, rst_b_, q_, d_, rstv_) \
    always_ff @(posedge clk_ or negedge rst_b_) begin \
        if (!rst_b_) q_ <= rstv_; \
        else q_ <= d_; \
    end
`endif

module mips_mult_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_STAGES = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mult_start_D,
    input  logic                  stall,
    input  logic [REG_ADDR_W-1:0] reg_dest_addr_mult,
    input  logic [DATA_W-1:0]     op_a_D,
    input  logic [DATA_W-1:0]     op_b_D,
    input  logic                  mult_signed_D,
    input  logic                  alu_wr_en_W,
    output logic                  mult_wr_en,
    output logic [REG_ADDR_W-1:0] mult_wr_addr,
    output logic [DATA_W-1:0]     mult_wr_data,
    output logic [DATA_W-1:0]     mult_hi,
    output logic [2:0]            mult_inflight,
    output logic                  port_conflict
);

    localparam int W_IDX = MULT_STAGES - 1;

    if (NUM_STAGES != MULT_STAGES || DATA_W != MULT_DATA_W || REG_ADDR_W != MULT_ADDR_W) begin : g_bad_cfg
        $error("mips_mult_pipe: unsupported parameter set");
    end

    t_mult_stage [MULT_STAGES-1:0] stage_q, stage_d;
    logic [DATA_W-1:0]             hi_q, hi_d;
    logic [2:0]                    inflight_q, inflight_d;
    logic                          conflict_q, conflict_d;

    logic                          issue;
    logic [DATA_W-1:0]             a_in, b_in;
    logic                          sign_in;
    logic [3:0][MULT_ACC_W-1:0]    step_acc_in, step_acc_out;
    logic [3:0][MULT_DATA_W-1:0]   step_a;
    logic [3:0][MULT_BYTE_W-1:0]   step_byte;
    logic                          unused_w;

    always_comb begin
        issue = mult_start_D & ~stall;
`ifdef MULT_SIGNED_EN
        if (mult_signed_D) begin
            a_in    = mag32(op_a_D);
            b_in    = mag32(op_b_D);
            sign_in = op_a_D[DATA_W-1] ^ op_b_D[DATA_W-1];
        end else begin
            a_in    = op_a_D;
            b_in    = op_b_D;
            sign_in = 1'b0;
        end
`else
        a_in    = op_a_D;
        b_in    = op_b_D;
        sign_in = 1'b0;
`endif
    end

`ifndef MULT_SIGNED_EN
    logic unused_signed;
    assign unused_signed = mult_signed_D;
`endif

    // P0 multiplies the issuing operands; Pn adds the next byte of b from stage n-1.
    always_comb begin
        step_acc_in[0] = '0;
        step_a[0]      = a_in;
        step_byte[0]   = b_in[7:0];
        for (int i = 1; i < 4; i++) begin
            step_acc_in[i] = stage_q[i-1].acc;
            step_a[i]      = stage_q[i-1].a;
            step_byte[i]   = stage_q[i-1].b[8*i +: 8];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_step
        mips_mult_byte_step u_step (
            .acc_in    (step_acc_in[g]),
            .a         (step_a[g]),
            .byte_in   (step_byte[g]),
            .shift_idx (2'(g)),
            .acc_out   (step_acc_out[g])
        );
    end

    always_comb begin
        stage_d[0] = '0;
        if (issue) begin
            stage_d[0].valid = 1'b1;
            stage_d[0].dest  = reg_dest_addr_mult;
            stage_d[0].a     = a_in;
            stage_d[0].b     = b_in;
            stage_d[0].acc   = step_acc_out[0];
            stage_d[0].sign  = sign_in;
        end
        for (int i = 1; i < 4; i++) begin
            stage_d[i]     = stage_q[i-1];
            stage_d[i].acc = step_acc_out[i];
        end
        stage_d[W_IDX] = stage_q[3];
`ifdef MULT_SIGNED_EN
        if (stage_q[3].sign) begin
            stage_d[W_IDX].acc = ~stage_q[3].acc + 64'd1;
        end
`endif
    end

    always_comb begin
        hi_d       = stage_q[W_IDX].valid ? stage_q[W_IDX].acc[63:32] : hi_q;
        conflict_d = conflict_q | (stage_q[W_IDX].valid & alu_wr_en_W);
        inflight_d = '0;
        for (int i = 0; i < MULT_STAGES; i++) begin
            inflight_d = inflight_d + 3'(stage_d[i].valid);
        end
    end

    `MIPS_DFF_AR(clk, rst, stage_q, stage_d, '0)
    `MIPS_DFF_AR(clk, rst, hi_q, hi_d, '0)
    `MIPS_DFF_AR(clk, rst, conflict_q, conflict_d, 1'b0)
    `MIPS_DFF_AR(clk, rst, inflight_q, inflight_d, '0)

    assign mult_wr_en    = stage_q[W_IDX].valid;
    assign mult_wr_addr  = stage_q[W_IDX].dest;
    assign mult_wr_data  = stage_q[W_IDX].acc[31:0];
    assign mult_hi       = hi_q;
    assign mult_inflight = inflight_q;
    assign port_conflict = conflict_q;
    assign unused_w      = ^{stage_q[W_IDX].a, stage_q[W_IDX].b, stage_q[W_IDX].sign};

endmodule

// File: doc/mips_mult_pipe.md
Name: mips_mult_pipe

Overview:
- Pipelined 32x32 integer multiplier feeding the shared register-file write port.
- Stages P0, P1, P2, P3, then W. Start, destination address and data advance together; the stall generator tracks the same stage names.
- The stall generator decides when a multiply may issue and prevents write-port and RAW hazards. This block executes the multiply and drives the W-stage register write, HI update and occupancy status.

Parameters:
- DATA_W, 32, operand and result-low width.
- REG_ADDR_W, 5, register address width.
- NUM_STAGES, 5, P0..P3 plus W; fixed, checked by elaboration assertion.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- mult_start_D  in  1  decode holds a multiply.
- stall  in  1  stall generator output; issue blocked while high.
- reg_dest_addr_mult  in  REG_ADDR_W  multiply destination register.
- op_a_D  in  DATA_W  multiplicand.
- op_b_D  in  DATA_W  multiplier.
- mult_signed_D  in  1  signed request; used only when MULT_SIGNED_EN is defined.
- alu_wr_en_W  in  1  ALU path writing the register file this cycle.
- mult_wr_en  out  1  register write strobe.
- mult_wr_addr  out  REG_ADDR_W  write address.
- mult_wr_data  out  DATA_W  product bits [31:0].
- mult_hi  out  DATA_W  HI register, product bits [63:32].
- mult_inflight  out  3  valid multiplies in P0..W, range 0..5.
- port_conflict  out  1  sticky error flag.

Behaviour:
- Issue: issue = mult_start_D & ~stall. Only an issue loads P0; every other cycle P0 loads a bubble.
  - Bubble: valid=0, data don't-care, no write.
- Pipeline is never stalled internally. Each stage register advances every cycle.
  - Per stage: valid, dest, a, b, 64-bit acc, sign flag.
- Multiply is shift-add, one byte of b per stage:
  - P0.acc = a*b[7:0]
  - P1.acc = P0.acc + (a*b[15:8] << 8)
  - P2.acc = P1.acc + (a*b[23:16] << 16)
  - P3.acc = P2.acc + (a*b[31:24] << 24)
  - All adds are 64-bit, no truncation; the 32x8 partial product is 40 bits.
- W latches P3. Outputs in the W cycle:
  - mult_wr_en = W.valid
  - mult_wr_addr = W.dest
  - mult_wr_data = W.acc[31:0]
- mult_hi updates to W.acc[63:32] on the clock edge ending the W cycle when W.valid. It holds otherwise.
- Latency: an issue at edge-cycle t gives mult_wr_en high in cycle t+5. Throughput is one multiply per cycle.
- Back-to-back issues to the same dest: writes land in order. The later write wins, including for HI.
- mult_inflight counts valid bits across P0..W, registered. Issue and W retire in the same cycle leave the count unchanged.
- port_conflict sets when mult_wr_en & alu_wr_en_W. It stays set until reset; multiply data is still written.
- Register 0: a write to address 0 is still emitted; the register file ignores it.
- Reset asserted mid-operation clears all valid bits immediately. Products in flight are lost, with no writes.
- Reset values: mult_wr_en=0, mult_wr_addr=0, mult_wr_data=0, mult_hi=0, mult_inflight=0, port_conflict=0. All stage registers reset to 0.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - At issue, when mult_signed_D=1, P0 stores |a| and |b|, plus sign = a[31]^b[31].
  - At W capture, acc is two's-complement negated if sign=1. Both the low word and HI then give the correct signed 64-bit product.
  - -2^31 operands are handled because the magnitude is 32-bit unsigned.
- Undefined: mult_signed_D is ignored, the sign flag is tied to 0 and the negation logic is absent. Unsigned only.

Decomposition:
- Shared package (mips_pkg):
  - MULT_STAGES = 5
  - MULT_BYTE_W = 8
  - typedef t_mult_stage: struct of valid, dest, a, b, acc[63:0], sign.
- One natural sub-module: mips_mult_byte_step. It is combinational: acc_in, a, byte, shift index in; acc_out out. It is instantiated four times.
- Stage registers use the codebase asynchronous-reset flop macro.

Test Plan:
- Unsigned issue of a=0x0000_0003, b=0x0000_0005, dest=7 at cycle 0 -> cycle 5: mult_wr_en=1, addr=7, data=0x0000_000F; mult_hi then reads 0.
- a=0xFFFF_FFFF, b=0xFFFF_FFFF unsigned -> data=0x0000_0001, mult_hi=0xFFFF_FFFE; with MULT_SIGNED_EN and signed=1 -> data=0x0000_0001, mult_hi=0.
- Five back-to-back issues, dest=1..5 -> writes in cycles 5..9 with matching addresses; mult_inflight reads 5 in cycle 5.
- mult_start_D=1 with stall=1 for 3 cycles, then stall=0 -> exactly one write, 5 cycles after stall drops; no write during the stall window.
- Issue at cycle 0, rst low in cycle 2 -> no write ever; all outputs 0; mult_inflight=0.
- Force alu_wr_en_W=1 in the cycle mult_wr_en=1 -> port_conflict=1 and it stays 1 until reset.
